// File: rtl/dbus_sram_bridge.sv
// rtl/dbus_sram_bridge.sv - MM-stage dbus to SRAM-like req/addr_ok/data_ok bridge
// Optional posted write buffer enabled by defining DBUS_WRITE_BUFFER_EN.
module dbus_sram_bridge #(
  parameter int MAP_KSEG = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbus_en,
  input  logic [3:0]        dbus_we,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [31:0]       dbus_data,
  output logic [31:0]       dbus_rdata,
  output logic              dbus_stall,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [3:0]        sram_wstrb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [31:0]       sram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef DBUS_WRITE_BUFFER_EN
  localparam logic WBUF = 1'b1;
`else
  localparam logic WBUF = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              posted_q, posted_d;
  logic              fin;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical memory.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
    if (MAP_KSEG != 0 && a[ADDR_W-1:ADDR_W-2] == 2'b10)
      return {3'b000, a[ADDR_W-4:0]};
    return a;
  endfunction

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    wstrb_d  = wstrb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    posted_d = posted_q;
    fin      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dbus_en) begin
          wr_d     = |dbus_we;
          wstrb_d  = dbus_we;
          addr_d   = map_addr(dbus_addr);
          wdata_d  = dbus_data;
          posted_d = WBUF & (|dbus_we);
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (sram_addr_ok) begin
          if (sram_data_ok) fin = 1'b1;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sram_data_ok) fin = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      // A posted write has no pipeline instruction waiting on it, so skip DONE.
      state_d = posted_q ? S_IDLE : S_DONE;
      if (!wr_q) rdata_d = sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      wstrb_q  <= 4'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      posted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      posted_q <= posted_d;
    end
  end

  always_comb begin
    dbus_stall = 1'b0;
    case (state_q)
      S_IDLE:         dbus_stall = dbus_en & ~(WBUF & (|dbus_we));
      S_REQ, S_WAIT:  dbus_stall = posted_q ? dbus_en : 1'b1;
      default:        dbus_stall = 1'b0;
    endcase
  end

  assign sram_req   = (state_q == S_REQ);
  assign sram_wr    = wr_q;
  assign sram_wstrb = wstrb_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign dbus_rdata = rdata_q;

endmodule

// File: tb/tb_dbus_sram_bridge.sv
// tb/tb_dbus_sram_bridge.sv - directed self-checking bench for dbus_sram_bridge
module tb_dbus_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbus_en;
  logic [3:0]  dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_data;
  logic [31:0] dbus_rdata, nm_rdata;
  logic        dbus_stall, nm_stall;
  logic        sram_req, nm_req;
  logic        sram_wr, nm_wr;
  logic [3:0]  sram_wstrb, nm_wstrb;
  logic [31:0] sram_addr, nm_addr;
  logic [31:0] sram_wdata, nm_wdata;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dbus_sram_bridge #(.MAP_KSEG(1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .dbus_en(dbus_en), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_data(dbus_data),
    .dbus_rdata(dbus_rdata), .dbus_stall(dbus_stall),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  dbus_sram_bridge #(.MAP_KSEG(0), .ADDR_W(32)) u_nomap (
    .clk(clk), .rst(rst),
    .dbus_en(dbus_en), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_data(dbus_data),
    .dbus_rdata(nm_rdata), .dbus_stall(nm_stall),
    .sram_req(nm_req), .sram_wr(nm_wr), .sram_wstrb(nm_wstrb),
    .sram_addr(nm_addr), .sram_wdata(nm_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; dbus_en = 1'b0; dbus_we = 4'b0; dbus_addr = 32'h0; dbus_data = 32'h0;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("reset_stall", {31'b0, dbus_stall}, 32'd0);
    check("reset_req", {31'b0, sram_req}, 32'd0);
    check("reset_rdata", dbus_rdata, 32'h0);
    check("reset_addr", sram_addr, 32'h0);

    // Load from kseg0, addr_ok in first REQ cycle, data_ok two cycles later.
    dbus_en = 1'b1; dbus_we = 4'b0000; dbus_addr = 32'h8000_0010;
    settle();
    check("ld_idle_stall", {31'b0, dbus_stall}, 32'd1);
    check("ld_idle_req", {31'b0, sram_req}, 32'd0);
    tick();
    check("ld_req", {31'b0, sram_req}, 32'd1);
    check("ld_addr", sram_addr, 32'h0000_0010);
    check("ld_wr", {31'b0, sram_wr}, 32'd0);
    check("ld_req_stall", {31'b0, dbus_stall}, 32'd1);
    sram_addr_ok = 1'b1;
    tick();
    sram_addr_ok = 1'b0;
    settle();
    check("ld_wait_req", {31'b0, sram_req}, 32'd0);
    check("ld_wait_stall1", {31'b0, dbus_stall}, 32'd1);
    tick();
    check("ld_wait_stall2", {31'b0, dbus_stall}, 32'd1);
    sram_data_ok = 1'b1; sram_rdata = 32'hDEAD_BEEF;
    tick();
    sram_data_ok = 1'b0; sram_rdata = 32'h0;
    settle();
    check("ld_done_stall", {31'b0, dbus_stall}, 32'd0);
    check("ld_rdata", dbus_rdata, 32'hDEAD_BEEF);
    dbus_en = 1'b0;
    tick();
    check("ld_idle_after", {31'b0, dbus_stall}, 32'd0);
    check("ld_idle_req_after", {31'b0, sram_req}, 32'd0);

    // Store from kseg1 with addr_ok and data_ok together.
    dbus_en = 1'b1; dbus_we = 4'b0011; dbus_addr = 32'hA000_0004; dbus_data = 32'h0000_1234;
    settle();
    check("st_idle_stall", {31'b0, dbus_stall}, 32'd1);
    tick();
    check("st_req", {31'b0, sram_req}, 32'd1);
    check("st_wr", {31'b0, sram_wr}, 32'd1);
    check("st_wstrb", {28'b0, sram_wstrb}, 32'h3);
    check("st_addr", sram_addr, 32'h0000_0004);
    check("st_wdata", sram_wdata, 32'h0000_1234);
    sram_addr_ok = 1'b1; sram_data_ok = 1'b1; sram_rdata = 32'h5555_5555;
    tick();
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
    settle();
    check("st_done_stall", {31'b0, dbus_stall}, 32'd0);
    check("st_done_req", {31'b0, sram_req}, 32'd0);
    check("st_rdata_kept", dbus_rdata, 32'hDEAD_BEEF);
    dbus_en = 1'b0; dbus_we = 4'b0;
    tick();

    // Load from kuseg-style address: no translation.
    dbus_en = 1'b1; dbus_addr = 32'h1FC0_0000;
    tick();
    check("nomap_addr", sram_addr, 32'h1FC0_0000);
    sram_addr_ok = 1'b1; sram_data_ok = 1'b1; sram_rdata = 32'h0BAD_F00D;
    tick();
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    settle();
    check("nomap_rdata", dbus_rdata, 32'h0BAD_F00D);
    dbus_en = 1'b0;
    tick();

    // kseg0 load into both instances, then addr_ok withheld for five cycles.
    dbus_en = 1'b1; dbus_addr = 32'h8000_0000;
    tick();
    check("map_kseg_on", sram_addr, 32'h0000_0000);
    check("map_kseg_off", nm_addr, 32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        dbus_addr = 32'h1234_5678; dbus_we = 4'b1111;
      end
      settle();
      check("hold_req", {31'b0, sram_req}, 32'd1);
      check("hold_addr", sram_addr, 32'h0000_0000);
      check("hold_wr", {31'b0, sram_wr}, 32'd0);
      tick();
    end
    sram_addr_ok = 1'b1;
    tick();
    sram_addr_ok = 1'b0;
    dbus_en = 1'b0; dbus_we = 4'b0;
    settle();
    check("rst_pre_stall", {31'b0, dbus_stall}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_req", {31'b0, sram_req}, 32'd0);
    check("rst_stall", {31'b0, dbus_stall}, 32'd0);
    check("rst_rdata", dbus_rdata, 32'h0);
    rst = 1'b0;
    tick();
    check("rst_idle_req", {31'b0, sram_req}, 32'd0);

`ifdef DBUS_WRITE_BUFFER_EN
    // Posted store followed immediately by a load.
    dbus_en = 1'b1; dbus_we = 4'b1111; dbus_addr = 32'h0000_0100; dbus_data = 32'hAA;
    settle();
    check("wb_st_stall", {31'b0, dbus_stall}, 32'd0);
    tick();
    dbus_we = 4'b0000; dbus_addr = 32'h0000_0200;
    settle();
    check("wb_ld_stall_drain", {31'b0, dbus_stall}, 32'd1);
    check("wb_drain_addr", sram_addr, 32'h0000_0100);
    sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
    tick();
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    settle();
    check("wb_ld_idle_stall", {31'b0, dbus_stall}, 32'd1);
    tick();
    check("wb_ld_addr", sram_addr, 32'h0000_0200);
    sram_addr_ok = 1'b1; sram_data_ok = 1'b1; sram_rdata = 32'h77;
    tick();
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    settle();
    check("wb_ld_done", {31'b0, dbus_stall}, 32'd0);
    check("wb_ld_rdata", dbus_rdata, 32'h77);
    dbus_en = 1'b0;
    tick();

    // Back-to-back stores.
    dbus_en = 1'b1; dbus_we = 4'b1111; dbus_addr = 32'h0000_0104;
    tick();
    dbus_addr = 32'h0000_0300;
    settle();
    check("wb_st2_stall", {31'b0, dbus_stall}, 32'd1);
    sram_addr_ok = 1'b1;
    tick();
    sram_addr_ok = 1'b0;
    settle();
    check("wb_st2_wait_stall", {31'b0, dbus_stall}, 32'd1);
    sram_data_ok = 1'b1;
    tick();
    sram_data_ok = 1'b0;
    settle();
    check("wb_st2_capture_stall", {31'b0, dbus_stall}, 32'd0);
    tick();
    dbus_en = 1'b0;
    check("wb_st2_addr", sram_addr, 32'h0000_0300);
    sram_addr_ok = 1'b1; sram_data_ok = 1'b1;
    tick();
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    check("wb_st2_idle", {31'b0, sram_req}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
